// File: rtl/id_exe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_pipe_reg
// Description : ID->EXE pipeline register with freeze, flush and bubble support.
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic [3:0]        id_exe_cmd,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic              id_imm,
    input  logic [11:0]       id_shift_operand,
    input  logic [23:0]       id_signed_imm_24,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [3:0]        id_sr,
    output logic              exe_valid,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_b,
    output logic              exe_s,
    output logic [3:0]        exe_exe_cmd,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic              exe_imm,
    output logic [11:0]       exe_shift_operand,
    output logic [23:0]       exe_signed_imm_24,
    output logic [REG_W-1:0]  exe_dest,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [3:0]        exe_sr
);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [3:0]        sr;
    } stage_t;

    stage_t stage_d;
    stage_t stage_q;

    // Freeze holds everything; flush zeroes the whole stage so bubble contents are deterministic.
    always_comb begin
        stage_d = stage_q;
        if (!freeze) begin
            if (flush) begin
                stage_d = '0;
            end else begin
                stage_d.valid         = id_valid;
                stage_d.wb_en         = id_wb_en    & id_valid;
                stage_d.mem_r_en      = id_mem_r_en & id_valid;
                stage_d.mem_w_en      = id_mem_w_en & id_valid;
                stage_d.b             = id_b        & id_valid;
                stage_d.s             = id_s        & id_valid;
                stage_d.exe_cmd       = id_exe_cmd;
                stage_d.pc            = id_pc;
                stage_d.val_rn        = id_val_rn;
                stage_d.val_rm        = id_val_rm;
                stage_d.imm           = id_imm;
                stage_d.shift_operand = id_shift_operand;
                stage_d.signed_imm_24 = id_signed_imm_24;
                stage_d.dest          = id_dest;
                stage_d.src1          = id_src1;
                stage_d.src2          = id_src2;
                stage_d.sr            = id_sr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign exe_valid         = stage_q.valid;
    assign exe_wb_en         = stage_q.wb_en;
    assign exe_mem_r_en      = stage_q.mem_r_en;
    assign exe_mem_w_en      = stage_q.mem_w_en;
    assign exe_b             = stage_q.b;
    assign exe_s             = stage_q.s;
    assign exe_exe_cmd       = stage_q.exe_cmd;
    assign exe_pc            = stage_q.pc;
    assign exe_val_rn        = stage_q.val_rn;
    assign exe_val_rm        = stage_q.val_rm;
    assign exe_imm           = stage_q.imm;
    assign exe_shift_operand = stage_q.shift_operand;
    assign exe_signed_imm_24 = stage_q.signed_imm_24;
    assign exe_dest          = stage_q.dest;
    assign exe_src1          = stage_q.src1;
    assign exe_src2          = stage_q.src2;
    assign exe_sr            = stage_q.sr;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_pipe_reg
// Description : Directed self-checking bench for id_exe_pipe_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } fields_t;

    logic    clk;
    logic    rst;
    logic    freeze;
    logic    flush;
    fields_t id;
    fields_t obs;
    fields_t exp_f;
    fields_t snap_a;
    fields_t snap_b;
    int      checks;
    int      failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_exe_pipe_reg #(.DATA_W(32), .REG_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .id_valid          (id.valid),
        .id_wb_en          (id.wb_en),
        .id_mem_r_en       (id.mem_r_en),
        .id_mem_w_en       (id.mem_w_en),
        .id_b              (id.b),
        .id_s              (id.s),
        .id_exe_cmd        (id.exe_cmd),
        .id_pc             (id.pc),
        .id_val_rn         (id.val_rn),
        .id_val_rm         (id.val_rm),
        .id_imm            (id.imm),
        .id_shift_operand  (id.shift_operand),
        .id_signed_imm_24  (id.signed_imm_24),
        .id_dest           (id.dest),
        .id_src1           (id.src1),
        .id_src2           (id.src2),
        .id_sr             (id.sr),
        .exe_valid         (obs.valid),
        .exe_wb_en         (obs.wb_en),
        .exe_mem_r_en      (obs.mem_r_en),
        .exe_mem_w_en      (obs.mem_w_en),
        .exe_b             (obs.b),
        .exe_s             (obs.s),
        .exe_exe_cmd       (obs.exe_cmd),
        .exe_pc            (obs.pc),
        .exe_val_rn        (obs.val_rn),
        .exe_val_rm        (obs.val_rm),
        .exe_imm           (obs.imm),
        .exe_shift_operand (obs.shift_operand),
        .exe_signed_imm_24 (obs.signed_imm_24),
        .exe_dest          (obs.dest),
        .exe_src1          (obs.src1),
        .exe_src2          (obs.src2),
        .exe_sr            (obs.sr)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_all(input string tag, input fields_t e);
        chk({tag, ".valid"},         32'(obs.valid),         32'(e.valid));
        chk({tag, ".wb_en"},         32'(obs.wb_en),         32'(e.wb_en));
        chk({tag, ".mem_r_en"},      32'(obs.mem_r_en),      32'(e.mem_r_en));
        chk({tag, ".mem_w_en"},      32'(obs.mem_w_en),      32'(e.mem_w_en));
        chk({tag, ".b"},             32'(obs.b),             32'(e.b));
        chk({tag, ".s"},             32'(obs.s),             32'(e.s));
        chk({tag, ".exe_cmd"},       32'(obs.exe_cmd),       32'(e.exe_cmd));
        chk({tag, ".pc"},            obs.pc,                 e.pc);
        chk({tag, ".val_rn"},        obs.val_rn,             e.val_rn);
        chk({tag, ".val_rm"},        obs.val_rm,             e.val_rm);
        chk({tag, ".imm"},           32'(obs.imm),           32'(e.imm));
        chk({tag, ".shift_operand"}, 32'(obs.shift_operand), 32'(e.shift_operand));
        chk({tag, ".signed_imm_24"}, 32'(obs.signed_imm_24), 32'(e.signed_imm_24));
        chk({tag, ".dest"},          32'(obs.dest),          32'(e.dest));
        chk({tag, ".src1"},          32'(obs.src1),          32'(e.src1));
        chk({tag, ".src2"},          32'(obs.src2),          32'(e.src2));
        chk({tag, ".sr"},            32'(obs.sr),            32'(e.sr));
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        freeze   = 1'b0;
        flush    = 1'b0;
        id       = '0;
        id.valid = 1'b1;
        id.wb_en = 1'b1;
        id.pc    = 32'hDEAD_BEEF;
        #1;
        chk_all("reset", '0);

        @(negedge clk);
        rst = 1'b1;

        // Test 1: plain load
        id               = '0;
        id.valid         = 1'b1;
        id.wb_en         = 1'b1;
        id.dest          = 4'd3;
        id.val_rn        = 32'h1234_5678;
        id.src1          = 4'd5;
        id.exe_cmd       = 4'b0010;
        id.pc            = 32'h0000_0104;
        id.val_rm        = 32'hA5A5_0F0F;
        id.imm           = 1'b1;
        id.shift_operand = 12'hABC;
        id.signed_imm_24 = 24'h80_0001;
        id.src2          = 4'd9;
        id.sr            = 4'b1010;
        id.s             = 1'b1;
        exp_f            = id;
        tick();
        chk_all("load1", exp_f);
        chk("load1.exe_wb_en", 32'(obs.wb_en), 32'd1);
        chk("load1.exe_dest",  32'(obs.dest),  32'd3);
        chk("load1.val_rn",    obs.val_rn,     32'h1234_5678);
        chk("load1.src1",      32'(obs.src1),  32'd5);

        // Test 2: freeze for three cycles while ID changes
        snap_a           = exp_f;
        freeze           = 1'b1;
        id               = '0;
        id.valid         = 1'b1;
        id.mem_r_en      = 1'b1;
        id.b             = 1'b1;
        id.exe_cmd       = 4'b1001;
        id.pc            = 32'h0000_0200;
        id.val_rn        = 32'h0BAD_F00D;
        id.val_rm        = 32'h7FFF_FFFF;
        id.shift_operand = 12'h5A5;
        id.signed_imm_24 = 24'hFF_FFFE;
        id.dest          = 4'd14;
        id.src1          = 4'd1;
        id.src2          = 4'd15;
        id.sr            = 4'b0101;
        snap_b           = id;
        tick();
        chk_all("freeze_c1", snap_a);
        id.val_rn = 32'h1111_2222;
        snap_b.val_rn = 32'h1111_2222;
        tick();
        chk_all("freeze_c2", snap_a);
        flush = 1'b1;
        tick();
        chk_all("freeze_c3", snap_a);
        flush  = 1'b0;
        freeze = 1'b0;
        tick();
        chk_all("unfreeze", snap_b);

        // Test 3: flush with a valid store in ID
        id               = '0;
        id.valid         = 1'b1;
        id.mem_w_en      = 1'b1;
        id.val_rm        = 32'hFFFF_FFFF;
        id.dest          = 4'd6;
        id.src2          = 4'd2;
        id.pc            = 32'h0000_0300;
        flush            = 1'b1;
        tick();
        chk_all("flush", '0);

        // Test 4: freeze and flush together hold; flush alone then bubbles
        flush = 1'b0;
        tick();
        exp_f = id;
        chk_all("reload", exp_f);
        freeze   = 1'b1;
        flush    = 1'b1;
        id.val_rn = 32'h3333_4444;
        tick();
        chk_all("frz_flush_hold", exp_f);
        freeze = 1'b0;
        tick();
        chk_all("flush_after_frz", '0);

        // Test 5: ID bubble gates control but keeps tags/data
        flush          = 1'b0;
        id             = '0;
        id.valid       = 1'b0;
        id.wb_en       = 1'b1;
        id.mem_r_en    = 1'b1;
        id.mem_w_en    = 1'b1;
        id.b           = 1'b1;
        id.s           = 1'b1;
        id.dest        = 4'd7;
        id.val_rn      = 32'hCAFE_0001;
        id.exe_cmd     = 4'b0110;
        exp_f          = '0;
        exp_f.dest     = 4'd7;
        exp_f.val_rn   = 32'hCAFE_0001;
        exp_f.exe_cmd  = 4'b0110;
        tick();
        chk_all("id_bubble", exp_f);

        // Test 6: asynchronous reset between edges
        id           = '0;
        id.valid     = 1'b1;
        id.wb_en     = 1'b1;
        id.dest      = 4'd12;
        id.val_rm    = 32'h0000_00FF;
        tick();
        chk("pre_rst.valid", 32'(obs.valid), 32'd1);
        rst = 1'b0;
        #1;
        chk_all("async_rst", '0);
        #2;
        rst          = 1'b1;
        id.dest      = 4'd8;
        id.src1      = 4'd4;
        exp_f        = id;
        tick();
        chk_all("post_rst_load", exp_f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
